// File: rtl/bbm_mux_if.sv
// Selector bus: channel data in, select request handshake, connection status out.
interface bbm_mux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] din;
  logic [SELW-1:0]      sel_req;
  logic                 sel_valid;
  logic                 sel_ready;
  logic [WIDTH-1:0]     out;
  logic                 out_en;
  logic [SELW-1:0]      cur_sel;
  logic                 busy;
  logic                 sel_err;

  modport master (
    output din, sel_req, sel_valid,
    input  sel_ready, out, out_en, cur_sel, busy, sel_err
  );

  modport slave (
    input  din, sel_req, sel_valid,
    output sel_ready, out, out_en, cur_sel, busy, sel_err
  );
endinterface

// File: rtl/bbm_mux.sv
// NCH:1 registered data selector with break-before-make switching: every channel
// change disconnects the output for DEAD cycles before the new channel is connected.
module bbm_mux #(
  parameter int               WIDTH    = 8,
  parameter int               NCH      = 4,
  parameter int               SELW     = 2,
  parameter int               DEAD     = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input logic    clock,
  input logic    reset,
  bbm_mux_if.slave bus
);
  localparam int CW = $clog2(DEAD + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_CONN = 2'd2;

  logic [1:0]       state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [SELW-1:0]  pend, nxt_pend;
  logic [SELW-1:0]  cur_sel_q, nxt_sel;
  logic             nxt_err;
  logic [WIDTH-1:0] out_q, conn_data;
  logic             out_en_q, busy_q, sel_err_q;
  logic             accept;

  // Full-width compare against NCH so out-of-range selects never wrap.
  function automatic logic in_range(input logic [SELW-1:0] s);
    return 32'(s) < 32'(NCH);
  endfunction

  assign bus.sel_ready = (state != ST_DEAD);
  assign accept        = bus.sel_valid && (state != ST_DEAD);

  // Next-state, dead counter, pending channel and error pulse.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pend  = pend;
    nxt_sel   = cur_sel_q;
    nxt_err   = 1'b0;
    case (state)
      ST_IDLE, ST_CONN: begin
        if (accept && !(state == ST_CONN && bus.sel_req == cur_sel_q)) begin
          nxt_state = ST_DEAD;
          nxt_cnt   = CW'(DEAD);
          nxt_pend  = bus.sel_req;
          nxt_err   = !in_range(bus.sel_req);
        end
      end
      ST_DEAD: begin
        if (cnt <= CW'(1)) begin
          nxt_cnt = '0;
          if (in_range(pend)) begin
            nxt_state = ST_CONN;
            nxt_sel   = pend;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Data of the channel that will be connected after this edge.
  always_comb begin
    conn_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(nxt_sel) == k) conn_data = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // State and registered outputs; reset drops any pending switch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend      <= '0;
      cur_sel_q <= '0;
      out_q     <= IDLE_VAL;
      out_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      pend      <= nxt_pend;
      cur_sel_q <= nxt_sel;
      out_q     <= (nxt_state == ST_CONN) ? conn_data : IDLE_VAL;
      out_en_q  <= (nxt_state == ST_CONN);
      busy_q    <= (nxt_state == ST_DEAD);
      sel_err_q <= nxt_err;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_en  = out_en_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.busy    = busy_q;
  assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_bbm_mux.sv
// Directed bench for bbm_mux: a 4-channel instance driven from a vector table,
// and a 3-channel instance with non-zero idle value for out-of-range requests.
module tb_bbm_mux;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  bbm_mux_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus_a ();
  bbm_mux_if #(.WIDTH(8), .NCH(3), .SELW(2)) bus_b ();

  bbm_mux #(.WIDTH(8), .NCH(4), .SELW(2), .DEAD(2), .IDLE_VAL(8'h00))
    u_dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
  bbm_mux #(.WIDTH(8), .NCH(3), .SELW(2), .DEAD(2), .IDLE_VAL(8'h5A))
    u_dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  typedef struct packed {
    logic [31:0] din;
    logic [1:0]  req;
    logic        vld;
    logic [7:0]  o;
    logic        en;
    logic [1:0]  cs;
    logic        bz;
    logic        er;
    logic        rdy;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] o, input logic en,
                       input logic [1:0] cs, input logic bz, input logic rdy);
    chk({tag, ".out"},       32'(bus_a.out),       32'(o));
    chk({tag, ".out_en"},    32'(bus_a.out_en),    32'(en));
    chk({tag, ".cur_sel"},   32'(bus_a.cur_sel),   32'(cs));
    chk({tag, ".busy"},      32'(bus_a.busy),      32'(bz));
    chk({tag, ".sel_ready"}, 32'(bus_a.sel_ready), 32'(rdy));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] o, input logic en,
                       input logic [1:0] cs, input logic bz, input logic er, input logic rdy);
    chk({tag, ".out"},       32'(bus_b.out),       32'(o));
    chk({tag, ".out_en"},    32'(bus_b.out_en),    32'(en));
    chk({tag, ".cur_sel"},   32'(bus_b.cur_sel),   32'(cs));
    chk({tag, ".busy"},      32'(bus_b.busy),      32'(bz));
    chk({tag, ".sel_err"},   32'(bus_b.sel_err),   32'(er));
    chk({tag, ".sel_ready"}, 32'(bus_b.sel_ready), 32'(rdy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // din = {ch3, ch2, ch1, ch0}
    //            din           req   vld   out    en    cs    bz    er    rdy
    tv[0]  = '{32'h44A52211, 2'd2, 1'b1, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{32'h44A52211, 2'd2, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{32'h44A52211, 2'd2, 1'b0, 8'hA5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{32'h44B62211, 2'd2, 1'b1, 8'hB6, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{32'h44C72211, 2'd2, 1'b1, 8'hC7, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{32'h44D82211, 2'd1, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{32'h44D82211, 2'd3, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{32'h44D82211, 2'd3, 1'b1, 8'h22, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{32'h44D82F11, 2'd1, 1'b0, 8'h2F, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{32'h44D82F11, 2'd0, 1'b1, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    tv[10] = '{32'h44D82F11, 2'd0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{32'h44D82F9C, 2'd0, 1'b0, 8'h9C, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{32'h44D82F00, 2'd0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};

    bus_a.din = '0; bus_a.sel_req = '0; bus_a.sel_valid = 1'b0;
    bus_b.din = 24'hC3B2A1; bus_b.sel_req = '0; bus_b.sel_valid = 1'b0;

    // Power-on reset, checked asynchronously before any clock edge.
    #1 reset = 1'b1;
    #2;
    chk_a("por_a", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_b("por_b", 8'h5A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_a("idle_a", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

    // Table: connect ch2, no-op re-request, switch to ch1 with ignored requests, switch to ch0.
    for (int i = 0; i < 13; i++) begin
      bus_a.din       = tv[i].din;
      bus_a.sel_req   = tv[i].req;
      bus_a.sel_valid = tv[i].vld;
      tick();
      chk_a($sformatf("v%0d", i), tv[i].o, tv[i].en, tv[i].cs, tv[i].bz, tv[i].rdy);
      chk($sformatf("v%0d.sel_err", i), 32'(bus_a.sel_err), 32'(tv[i].er));
    end

    // Async reset mid-stream while connected to ch0.
    bus_a.sel_valid = 1'b0;
    bus_a.din = 32'h44D82F77;
    tick();
    chk("rst_pre.out", 32'(bus_a.out), 32'h77);
    #3 reset = 1'b1;
    #1;
    chk_a("rst_async_a", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_b("rst_async_b", 8'h5A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    chk_a("rst_rel_a", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

    // Instance B: connect ch1, then request out-of-range channel 3.
    bus_b.sel_req = 2'd1; bus_b.sel_valid = 1'b1;
    tick();
    chk_b("b_sw1", 8'h5A, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    bus_b.sel_valid = 1'b0;
    tick();
    chk_b("b_sw2", 8'h5A, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("b_conn", 8'hB2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    bus_b.sel_req = 2'd3; bus_b.sel_valid = 1'b1;
    tick();
    chk_b("b_err1", 8'h5A, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    bus_b.sel_valid = 1'b0;
    tick();
    chk_b("b_err2", 8'h5A, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_b("b_err3", 8'h5A, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_b("b_err4", 8'h5A, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);

    // Instance A: reset during the second dead cycle drops the pending switch to ch3.
    bus_a.sel_req = 2'd3; bus_a.sel_valid = 1'b1;
    tick();
    chk_a("dr_d1", 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    bus_a.sel_valid = 1'b0;
    tick();
    chk_a("dr_d2", 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk_a("dr_async", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    chk_a("dr_rel1", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    chk_a("dr_rel2", 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);

    // A fresh request after that reset still connects normally.
    bus_a.sel_req = 2'd1; bus_a.sel_valid = 1'b1;
    tick();
    bus_a.sel_valid = 1'b0;
    tick();
    tick();
    chk_a("dr_new", 8'h2F, 1'b1, 2'd1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
